// File: rtl/io_timer_intr.sv
// io_timer_intr: memory-mapped interval timer with prescaler, auto-reload and
// an interrupt request/acknowledge handshake toward the MCU.
module io_timer_intr #(
  parameter logic [11:0] BASE_ADDR = 12'hFF0,
  parameter int          CNT_W     = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        io_cs,
  input  logic        io_wr,
  input  logic        io_rd,
  input  logic [11:0] Address,
  input  logic [31:0] IO_in,
  output logic [31:0] IO_out,
  output logic        intr,
  input  logic        int_ack
);

  typedef enum logic [1:0] {IDLE, REQ, ACKW} state_t;

  localparam logic [1:0] R_CTRL   = 2'd0;
  localparam logic [1:0] R_COUNT  = 2'd1;
  localparam logic [1:0] R_RELOAD = 2'd2;
  localparam logic [1:0] R_STATUS = 2'd3;

  state_t           state;
  logic             en, auto_rl, ie;
  logic [7:0]       pre, psc;
  logic [CNT_W-1:0] count, reload;
  logic             exp_flag, ovr, pend;
  logic [31:0]      rdata;

  // Address bits 1:0 are byte lanes within a word and carry no meaning here.
  logic unused_addr;
  assign unused_addr = ^Address[1:0];

  logic       hit, we, re;
  logic [1:0] wsel;
  assign hit  = (Address[11:4] == BASE_ADDR[11:4]);
  assign wsel = Address[3:2];
  assign we   = io_cs & io_wr & hit;
  assign re   = io_cs & io_rd & hit;

  logic wr_ctrl, wr_count, wr_reload, wr_status;
  assign wr_ctrl   = we && (wsel == R_CTRL);
  assign wr_count  = we && (wsel == R_COUNT);
  assign wr_reload = we && (wsel == R_RELOAD);
  assign wr_status = we && (wsel == R_STATUS);

  // tick fires on the cycle the prescaler reaches PRE; expiry is a tick with COUNT at zero
  logic tick, expiry, exp_ev;
  assign tick   = en && (psc == pre);
  assign expiry = tick && (count == '0);
  assign exp_ev = expiry && ie;

  // Control, prescaler and counter state; CPU writes are placed last so they win.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en       <= 1'b0;
      auto_rl  <= 1'b0;
      ie       <= 1'b0;
      pre      <= '0;
      psc      <= '0;
      count    <= '0;
      reload   <= '0;
      exp_flag <= 1'b0;
    end else begin
      if (!en || tick) psc <= '0;
      else             psc <= psc + 8'd1;

      if (tick && count != '0) count <= count - CNT_W'(1);
      if (expiry) begin
        if (auto_rl) count <= reload;
        else         en    <= 1'b0;
      end

      if (wr_status && IO_in[0]) exp_flag <= 1'b0;
      if (expiry)                exp_flag <= 1'b1;

      if (wr_ctrl) begin
        en      <= IO_in[0];
        auto_rl <= IO_in[1];
        ie      <= IO_in[2];
        pre     <= IO_in[15:8];
        // restart the prescale phase so a new PRE never starts past its limit
        psc     <= '0;
      end
      if (wr_count)  count  <= IO_in[CNT_W-1:0];
      if (wr_reload) reload <= IO_in[CNT_W-1:0];
    end
  end

  // Interrupt handshake FSM with one-deep pending and overrun tracking.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      intr  <= 1'b0;
      pend  <= 1'b0;
      ovr   <= 1'b0;
    end else begin
      if (wr_status && IO_in[1]) ovr <= 1'b0;
      case (state)
        IDLE: begin
          if (exp_ev) begin
            state <= REQ;
            intr  <= 1'b1;
          end
        end
        REQ: begin
          if (int_ack) begin
            state <= ACKW;
            intr  <= 1'b0;
          end
          if (exp_ev) begin
            if (pend) ovr  <= 1'b1;
            else      pend <= 1'b1;
          end
        end
        ACKW: begin
          if (!int_ack) begin
            // an expiry landing on the exit cycle is served directly or kept pending
            if (pend || exp_ev) begin
              state <= REQ;
              intr  <= 1'b1;
              pend  <= pend && exp_ev;
            end else begin
              state <= IDLE;
            end
          end else if (exp_ev) begin
            if (pend) ovr  <= 1'b1;
            else      pend <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          intr  <= 1'b0;
        end
      endcase
    end
  end

  // Register read mux; unused bits read as zero.
  always_comb begin
    rdata = '0;
    case (wsel)
      R_CTRL:   rdata = {16'b0, pre, 5'b0, ie, auto_rl, en};
      R_COUNT:  rdata[CNT_W-1:0] = count;
      R_RELOAD: rdata[CNT_W-1:0] = reload;
      R_STATUS: rdata = {28'b0, pend, intr, ovr, exp_flag};
      default:  rdata = '0;
    endcase
  end

  assign IO_out = re ? rdata : 32'hz;

endmodule

// File: tb/tb_io_timer_intr.sv
// Scoreboard bench for io_timer_intr: expectations are queued as stimulus is
// applied and popped when the corresponding DUT output is observed.
module tb_io_timer_intr;

  logic        clk;
  logic        reset;
  logic        io_cs, io_wr, io_rd;
  logic [11:0] Address;
  logic [31:0] IO_in;
  wire  [31:0] IO_out;
  logic        intr;
  logic        int_ack;

  localparam logic [11:0] A_CTRL   = 12'hFF0;
  localparam logic [11:0] A_COUNT  = 12'hFF4;
  localparam logic [11:0] A_RELOAD = 12'hFF8;
  localparam logic [11:0] A_STATUS = 12'hFFC;

  int          checks = 0;
  int          errors = 0;
  string       nq[$];
  logic [31:0] vq[$];
  string       exp_n;
  logic [31:0] exp_v;
  logic [31:0] obs;

  io_timer_intr dut (
    .clk(clk), .reset(reset), .io_cs(io_cs), .io_wr(io_wr), .io_rd(io_rd),
    .Address(Address), .IO_in(IO_in), .IO_out(IO_out), .intr(intr), .int_ack(int_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push(input string n, input logic [31:0] v);
    nq.push_back(n);
    vq.push_back(v);
  endtask

  // leaves the bench aligned just after a falling edge
  task automatic apply_reset;
    reset = 1'b0; io_cs = 1'b0; io_rd = 1'b0; io_wr = 1'b0;
    int_ack = 1'b0; Address = '0; IO_in = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // one-cycle write: the register updates on the rising edge in between
  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    io_cs = 1'b1; io_wr = 1'b1; Address = a; IO_in = d;
    @(negedge clk);
    io_cs = 1'b0; io_wr = 1'b0;
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] d);
    io_cs = 1'b1; io_rd = 1'b1; Address = a;
    #1 d = IO_out;
    io_cs = 1'b0; io_rd = 1'b0;
  endtask

  task automatic test_reset;
    apply_reset;
    wr(A_COUNT, 32'd0);
    wr(A_CTRL, 32'h5);
    @(negedge clk);
    push("intr_before_reset", 32'd1);
    obs = {31'b0, intr};
    checks++; exp_v = vq.pop_front(); exp_n = nq.pop_front();
    if (obs !== exp_v) begin errors++; $display("FAIL %s got %h expected %h", exp_n, obs, exp_v); end
    #2 reset = 1'b0;
    #1;
    push("intr_async_clear", 32'd0);
    obs = {31'b0, intr};
    checks++; exp_v = vq.pop_front(); exp_n = nq.pop_front();
    if (obs !== exp_v) begin errors++; $display("FAIL %s got %h expected %h", exp_n, obs, exp_v); end
    for (int i = 0; i < 4; i++) begin
      push($sformatf("reset_reg%0d", i), 32'd0);
      rd(A_CTRL + 12'(4 * i), obs);
      checks++; exp_v = vq.pop_front(); exp_n = nq.pop_front();
      if (obs !== exp_v) begin errors++; $display("FAIL %s got %h expected %h", exp_n, obs, exp_v); end
    end
    @(negedge clk);
    reset = 1'b1;
    push("io_out_unselected", 32'hz);
    #1 obs = IO_out;
    checks++; exp_v = vq.pop_front(); exp_n = nq.pop_front();
    if (obs !== exp_v) begin errors++; $display("FAIL %s got %h expected %h", exp_n, obs, exp_v); end
  endtask

  task automatic test_oneshot;
    apply_reset;
    wr(A_RELOAD, 32'd0);
    wr(A_COUNT, 32'd3);
    wr(A_CTRL, 32'h5);
    for (int i = 0; i < 5; i++) push($sformatf("oneshot_intr_c%0d", i), (i == 4) ? 32'd1 : 32'd0);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      obs = {31'b0, intr};
      checks++; exp_v = vq.pop_front(); exp_n = nq.pop_front();
      if (obs !== exp_v) begin errors++; $display("FAIL %s got %h expected %h", exp_n, obs, exp_v); end
    end
    push("oneshot_ctrl_en_clr", 32'h4);
    push("oneshot_status", 32'h5);
    push("oneshot_count", 32'h0);
    rd(A_CTRL, obs);
    checks++; exp_v = vq.pop_front(); exp_n = nq.pop_front();
    if (obs !== exp_v) begin errors++; $display("FAIL %s got %h expected %h", exp_n, obs, exp_v); end
    rd(A_STATUS, obs);
    checks++; exp_v = vq.pop_front(); exp_n = nq.pop_front();
    if (obs !== exp_v) begin errors++; $display("FAIL %s got %h expected %h", exp_n, obs, exp_v); end
    rd(A_COUNT, obs);
    checks++; exp_v = vq.pop_front(); exp_n = nq.pop_front();
    if (obs !== exp_v) begin errors++; $display("FAIL %s got %h expected %h", exp_n, obs, exp_v); end
    int_ack = 1'b1;
    @(negedge clk);
    push("oneshot_ack_drop", 32'd0);
    obs = {31'b0, intr};
    checks++; exp_v = vq.pop_front(); exp_n = nq.pop_front();
    if (obs !== exp_v) begin errors++; $display("FAIL %s got %h expected %h", exp_n, obs, exp_v); end
    int_ack = 1'b0;
    @(negedge clk);
    push("oneshot_status_after_ack", 32'h1);
    rd(A_STATUS, obs);
    checks++; exp_v = vq.pop_front(); exp_n = nq.pop_front();
    if (obs !== exp_v) begin errors++; $display("FAIL %s got %h expected %h", exp_n, obs, exp_v); end
    wr(A_STATUS, 32'h1);
    push("oneshot_exp_w1c", 32'h0);
    rd(A_STATUS, obs);
    checks++; exp_v = vq.pop_front(); exp_n = nq.pop_front();
    if (obs !== exp_v) begin errors++; $display("FAIL %s got %h expected %h", exp_n, obs, exp_v); end
  endtask

  task automatic test_autoreload;
    logic [31:0] seq [12];
    seq = '{1, 1, 0, 0, 2, 2, 1, 1, 0, 0, 2, 2};
    apply_reset;
    wr(A_RELOAD, 32'd2);
    wr(A_COUNT, 32'd1);
    wr(A_CTRL, 32'h0107);
    for (int i = 0; i < 12; i++) push($sformatf("auto_count_c%0d", i), seq[i]);
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      rd(A_COUNT, obs);
      checks++; exp_v = vq.pop_front(); exp_n = nq.pop_front();
      if (obs !== exp_v) begin errors++; $display("FAIL %s got %h expected %h", exp_n, obs, exp_v); end
    end
    push("auto_status_two_expiries", 32'hD);
    rd(A_STATUS, obs);
    checks++; exp_v = vq.pop_front(); exp_n = nq.pop_front();
    if (obs !== exp_v) begin errors++; $display("FAIL %s got %h expected %h", exp_n, obs, exp_v); end
  endtask

  task automatic test_handshake;
    apply_reset;
    wr(A_RELOAD, 32'd4);
    wr(A_COUNT, 32'd0);
    wr(A_CTRL, 32'h7);
    // expiries land on the 1st, 6th, 11th, 16th rising edge after the CTRL write
    for (int i = 0; i < 7; i++) push($sformatf("hs_hold_c%0d", i), (i == 0) ? 32'd0 : 32'd1);
    for (int i = 0; i < 7; i++) begin
      if (i > 0) @(negedge clk);
      obs = {31'b0, intr};
      checks++; exp_v = vq.pop_front(); exp_n = nq.pop_front();
      if (obs !== exp_v) begin errors++; $display("FAIL %s got %h expected %h", exp_n, obs, exp_v); end
    end
    push("hs_pend_set", 32'hD);
    rd(A_STATUS, obs);
    checks++; exp_v = vq.pop_front(); exp_n = nq.pop_front();
    if (obs !== exp_v) begin errors++; $display("FAIL %s got %h expected %h", exp_n, obs, exp_v); end
    int_ack = 1'b1;
    @(negedge clk);
    push("hs_ack_drop", 32'd0);
    obs = {31'b0, intr};
    checks++; exp_v = vq.pop_front(); exp_n = nq.pop_front();
    if (obs !== exp_v) begin errors++; $display("FAIL %s got %h expected %h", exp_n, obs, exp_v); end
    int_ack = 1'b0;
    @(negedge clk);
    push("hs_reassert", 32'd1);
    push("hs_pend_consumed", 32'h5);
    obs = {31'b0, intr};
    checks++; exp_v = vq.pop_front(); exp_n = nq.pop_front();
    if (obs !== exp_v) begin errors++; $display("FAIL %s got %h expected %h", exp_n, obs, exp_v); end
    rd(A_STATUS, obs);
    checks++; exp_v = vq.pop_front(); exp_n = nq.pop_front();
    if (obs !== exp_v) begin errors++; $display("FAIL %s got %h expected %h", exp_n, obs, exp_v); end
    repeat (3) @(negedge clk);
    push("hs_pend_again", 32'hD);
    rd(A_STATUS, obs);
    checks++; exp_v = vq.pop_front(); exp_n = nq.pop_front();
    if (obs !== exp_v) begin errors++; $display("FAIL %s got %h expected %h", exp_n, obs, exp_v); end
    repeat (5) @(negedge clk);
    push("hs_overrun", 32'hF);
    rd(A_STATUS, obs);
    checks++; exp_v = vq.pop_front(); exp_n = nq.pop_front();
    if (obs !== exp_v) begin errors++; $display("FAIL %s got %h expected %h", exp_n, obs, exp_v); end
    wr(A_STATUS, 32'h3);
    push("hs_w1c_exp_ovr", 32'hC);
    rd(A_STATUS, obs);
    checks++; exp_v = vq.pop_front(); exp_n = nq.pop_front();
    if (obs !== exp_v) begin errors++; $display("FAIL %s got %h expected %h", exp_n, obs, exp_v); end
  endtask

  task automatic test_bus;
    apply_reset;
    wr(A_RELOAD, 32'h1234);
    wr(12'h108, 32'h9999);
    push("bus_miss_io_out", 32'hz);
    rd(12'h108, obs);
    checks++; exp_v = vq.pop_front(); exp_n = nq.pop_front();
    if (obs !== exp_v) begin errors++; $display("FAIL %s got %h expected %h", exp_n, obs, exp_v); end
    push("bus_miss_no_change", 32'h1234);
    rd(A_RELOAD, obs);
    checks++; exp_v = vq.pop_front(); exp_n = nq.pop_front();
    if (obs !== exp_v) begin errors++; $display("FAIL %s got %h expected %h", exp_n, obs, exp_v); end
    push("bus_rdwr_old_value", 32'h1234);
    push("bus_rdwr_new_value", 32'h77);
    io_cs = 1'b1; io_wr = 1'b1; io_rd = 1'b1; Address = A_RELOAD; IO_in = 32'h77;
    #1 obs = IO_out;
    checks++; exp_v = vq.pop_front(); exp_n = nq.pop_front();
    if (obs !== exp_v) begin errors++; $display("FAIL %s got %h expected %h", exp_n, obs, exp_v); end
    @(negedge clk);
    io_cs = 1'b0; io_wr = 1'b0; io_rd = 1'b0;
    rd(A_RELOAD, obs);
    checks++; exp_v = vq.pop_front(); exp_n = nq.pop_front();
    if (obs !== exp_v) begin errors++; $display("FAIL %s got %h expected %h", exp_n, obs, exp_v); end
    wr(A_COUNT, 32'd5);
    wr(A_CTRL, 32'h1);
    wr(A_COUNT, 32'h40);
    push("bus_count_write_wins", 32'h40);
    push("bus_count_then_ticks", 32'h3F);
    rd(A_COUNT, obs);
    checks++; exp_v = vq.pop_front(); exp_n = nq.pop_front();
    if (obs !== exp_v) begin errors++; $display("FAIL %s got %h expected %h", exp_n, obs, exp_v); end
    @(negedge clk);
    rd(A_COUNT, obs);
    checks++; exp_v = vq.pop_front(); exp_n = nq.pop_front();
    if (obs !== exp_v) begin errors++; $display("FAIL %s got %h expected %h", exp_n, obs, exp_v); end
  endtask

  task automatic test_ie_off;
    apply_reset;
    wr(A_COUNT, 32'd2);
    wr(A_CTRL, 32'h1);
    for (int i = 0; i < 6; i++) push($sformatf("ieoff_intr_c%0d", i), 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      obs = {31'b0, intr};
      checks++; exp_v = vq.pop_front(); exp_n = nq.pop_front();
      if (obs !== exp_v) begin errors++; $display("FAIL %s got %h expected %h", exp_n, obs, exp_v); end
    end
    push("ieoff_status_exp", 32'h1);
    push("ieoff_ctrl_en_clr", 32'h0);
    rd(A_STATUS, obs);
    checks++; exp_v = vq.pop_front(); exp_n = nq.pop_front();
    if (obs !== exp_v) begin errors++; $display("FAIL %s got %h expected %h", exp_n, obs, exp_v); end
    rd(A_CTRL, obs);
    checks++; exp_v = vq.pop_front(); exp_n = nq.pop_front();
    if (obs !== exp_v) begin errors++; $display("FAIL %s got %h expected %h", exp_n, obs, exp_v); end
    int_ack = 1'b1;
    @(negedge clk);
    int_ack = 1'b0;
    @(negedge clk);
    push("ieoff_idle_ack_intr", 32'd0);
    push("ieoff_idle_ack_status", 32'h1);
    obs = {31'b0, intr};
    checks++; exp_v = vq.pop_front(); exp_n = nq.pop_front();
    if (obs !== exp_v) begin errors++; $display("FAIL %s got %h expected %h", exp_n, obs, exp_v); end
    rd(A_STATUS, obs);
    checks++; exp_v = vq.pop_front(); exp_n = nq.pop_front();
    if (obs !== exp_v) begin errors++; $display("FAIL %s got %h expected %h", exp_n, obs, exp_v); end
  endtask

  initial begin
    test_reset;
    test_oneshot;
    test_autoreload;
    test_handshake;
    test_bus;
    test_ie_off;
    if (vq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d leftover expected 0", vq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
